// File: rtl/burst_line_adaptor_pkg.sv
// Shared types and geometry helpers for the cache-line to memory-burst bridge.
package burst_adaptor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int calc_beats(input int line_w, input int burst_w);
      return line_w / burst_w;
   endfunction

   function automatic int calc_offs(input int line_w);
      return $clog2(line_w / 32'sd8);
   endfunction

   // Line must split evenly into a power-of-two number (>=2) of beats.
   function automatic bit geometry_ok(input int line_w, input int burst_w);
      int beats;
      if (burst_w <= 32'sd0) begin
         return 1'b0;
      end
      beats = line_w / burst_w;
      return ((line_w % burst_w) == 32'sd0) && (beats >= 32'sd2) &&
             ((beats & (beats - 32'sd1)) == 32'sd0);
   endfunction

endpackage

// File: rtl/burst_line_adaptor_beat_counter.sv
// Beat index within a line transfer; wraps naturally since the beat count is a power of two.
module beat_counter #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             i_clr,
   input  logic             i_en,
   output logic [CNT_W-1:0] o_cnt,
   output logic             o_last
);

   logic [CNT_W-1:0] r_cnt;

   // Beat counter: clear dominates, otherwise advance on each qualified beat.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en) begin
         r_cnt <= r_cnt + CNT_W'(1'b1);
      end else begin
         r_cnt <= r_cnt;
      end
   end

   assign o_cnt  = r_cnt;
   assign o_last = &r_cnt;

endmodule

// File: rtl/burst_line_adaptor.sv
// Bridges whole-line LLC requests onto a beat-by-beat burst memory port,
// tolerating memory stalls between beats.
module burst_line_adaptor
   import burst_adaptor_pkg::*;
#(
   parameter int LINE_W  = 256,
   parameter int BURST_W = 64,
   parameter int ADDR_W  = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [LINE_W-1:0]  line_i,
   output logic [LINE_W-1:0]  line_o,
   input  logic [ADDR_W-1:0]  address_i,
   input  logic               read_i,
   input  logic               write_i,
   output logic               resp_o,
   output logic               busy_o,
   input  logic [BURST_W-1:0] burst_i,
   output logic [BURST_W-1:0] burst_o,
   output logic [ADDR_W-1:0]  address_o,
   output logic               read_o,
   output logic               write_o,
   input  logic               resp_i
);

   localparam int BEATS = calc_beats(LINE_W, BURST_W);
   localparam int OFFS  = calc_offs(LINE_W);
   localparam int CNT_W = $clog2(BEATS);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << OFFS;

   if (!geometry_ok(LINE_W, BURST_W)) begin : g_bad_geometry
      $error("burst_line_adaptor: LINE_W/BURST_W must be a power of two >= 2");
   end

   state_t             r_state;
   state_t             w_next_state;
   logic [CNT_W-1:0]   w_cnt;
   logic               w_last;
   logic               w_clr;
   logic               w_en;
   logic               w_accept;
   logic               w_accept_wr;
   logic [LINE_W-1:0]  r_line;
   logic [LINE_W-1:0]  r_wbuf;
   logic [ADDR_W-1:0]  r_addr;
   logic               r_read;
   logic               r_write;
   logic               r_resp;
   logic               r_busy;

   assign w_clr       = (r_state == IDLE);
   assign w_en        = resp_i & ((r_state == READ) | (r_state == WRITE));
   assign w_accept    = (r_state == IDLE) & (read_i | write_i);
   assign w_accept_wr = (r_state == IDLE) & ~read_i & write_i;

   beat_counter #(
      .CNT_W (CNT_W)
   ) u_beat_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .i_clr   (w_clr),
      .i_en    (w_en),
      .o_cnt   (w_cnt),
      .o_last  (w_last)
   );

   // Next-state decode; reads win over writes when both are requested.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (read_i) begin
               w_next_state = READ;
            end else if (write_i) begin
               w_next_state = WRITE;
            end else begin
               w_next_state = IDLE;
            end
         end
         READ: begin
            if (resp_i && w_last) begin
               w_next_state = DONE;
            end else begin
               w_next_state = READ;
            end
         end
         WRITE: begin
            if (resp_i && w_last) begin
               w_next_state = DONE;
            end else begin
               w_next_state = WRITE;
            end
         end
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   // State register with control outputs registered from the next state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_read  <= 1'b0;
         r_write <= 1'b0;
         r_resp  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_read  <= (w_next_state == READ);
         r_write <= (w_next_state == WRITE);
         r_resp  <= (w_next_state == DONE);
         r_busy  <= (w_next_state != IDLE);
      end
   end

   // Request capture at acceptance and beat-wise assembly of the read line.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr <= '0;
         r_wbuf <= '0;
         r_line <= '0;
      end else begin
         if (w_accept) begin
            r_addr <= address_i & ALIGN_MASK;
         end
         if (w_accept_wr) begin
            r_wbuf <= line_i;
         end
         if ((r_state == READ) && resp_i) begin
            r_line[w_cnt*BURST_W +: BURST_W] <= burst_i;
         end
      end
   end

   // Write beat follows the counter directly so it holds across stalls.
   assign burst_o   = r_wbuf[w_cnt*BURST_W +: BURST_W];
   assign line_o    = r_line;
   assign address_o = r_addr;
   assign read_o    = r_read;
   assign write_o   = r_write;
   assign resp_o    = r_resp;
   assign busy_o    = r_busy;

endmodule
